// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Purpose:
//   Registered immediate-extension stage with valid/ready handshakes on both
//   sides. An accepted raw immediate is extended to OUT_W bits according to
//   in_mode. The result is registered and presented one cycle later.
//     00 SEXT  : sign-extend
//     01 ZEXT  : zero-extend
//     10 UPPER : immediate placed in the top bits, zeros below
//     11 BOFS  : sign-extend, then shift left by 2 (branch offset)
//
// Configuration:
//   IMM_EXT_SKID_EN - when defined, a one-entry skid buffer is compiled in.
//                     in_ready is then a pure register output with no
//                     combinational path from out_ready. When undefined,
//                     in_ready = ~out_valid | out_ready.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   in_valid  in   1      input qualifier
//   in_ready  out  1      block accepts the input this cycle
//   in_data   in   IN_W   raw immediate field
//   in_mode   in   2      extension mode
//   out_valid out  1      output qualifier
//   out_ready in   1      consumer accepts out_data this cycle
//   out_data  out  OUT_W  extended result
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SEXT  = 2'b00,
    MODE_ZEXT  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_BOFS  = 2'b11
  } extModeE;

  logic [OUT_W-1:0] sextVal;
  logic [OUT_W-1:0] extVal;

  logic             outValid_q, outValid_d;
  logic [OUT_W-1:0] outData_q,  outData_d;
  logic             acceptIn;
  logic             outFire;

  // Combinational extension of the presented immediate; only used on the
  // cycle it is accepted, so it is evaluated directly from the input pins.
  always_comb begin
    sextVal = {{PAD_W{in_data[IN_W-1]}}, in_data};
    extVal  = sextVal;
    case (extModeE'(in_mode))
      MODE_SEXT:  extVal = sextVal;
      MODE_ZEXT:  extVal = {{PAD_W{1'b0}}, in_data};
      MODE_UPPER: extVal = {in_data, {PAD_W{1'b0}}};
      MODE_BOFS:  extVal = sextVal << 2;
      default:    extVal = sextVal;
    endcase
  end

  assign acceptIn  = in_valid & in_ready;
  assign outFire   = outValid_q & out_ready;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;

`ifdef IMM_EXT_SKID_EN

  logic             skidValid_q, skidValid_d;
  logic [OUT_W-1:0] skidData_q,  skidData_d;
  logic             inReady_q,   inReady_d;
  logic             outCanLoad;

  // The output register may take a new value when it is empty or draining.
  assign outCanLoad = ~outValid_q | out_ready;
  assign in_ready   = inReady_q;

  // Next-state logic. A parked skid entry always has priority for the output
  // register, which preserves acceptance order. in_ready is low while the
  // skid entry is full, so no acceptance can coincide with a skid drain.
  always_comb begin
    outValid_d  = outValid_q;
    outData_d   = outData_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    if (outCanLoad) begin
      if (skidValid_q) begin
        outValid_d  = 1'b1;
        outData_d   = skidData_q;
        skidValid_d = 1'b0;
      end else if (acceptIn) begin
        outValid_d = 1'b1;
        outData_d  = extVal;
      end else if (outFire) begin
        outValid_d = 1'b0;
      end
    end else if (acceptIn) begin
      skidValid_d = 1'b1;
      skidData_d  = extVal;
    end
    inReady_d = ~skidValid_d;
  end

  // State registers; reset empties both entries and reopens the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      inReady_q   <= 1'b1;
    end else begin
      outValid_q  <= outValid_d;
      outData_q   <= outData_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      inReady_q   <= inReady_d;
    end
  end

`else

  // Without a skid entry the input is open whenever the output register is
  // empty or is being drained on this edge.
  assign in_ready = ~outValid_q | out_ready;

  // Next-state logic: a new acceptance overwrites (or refills) the output;
  // otherwise a drained output goes empty. out_data keeps its last value.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    if (acceptIn) begin
      outValid_d = 1'b1;
      outData_d  = extVal;
    end else if (outFire) begin
      outValid_d = 1'b0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

`endif

endmodule
